// File: rtl/lap_bank_ctrl.sv
// lap_bank_ctrl - lap-memory controller for the stopwatch.
// Stores up to DEPTH = 2**AW lap entries ({min,s,ms}, BCD bytes) while in
// record mode and steps through them oldest-first while in recall mode.
// Optional build macro: LAP_OVERWRITE_EN. When it is defined, a lap taken while
// the bank is full overwrites the oldest entry, so the bank holds the last DEPTH
// laps. When it is undefined, a lap taken while the bank is full is ignored.
//
// state  | meaning
// S_REC  | record: LAP stores a lap, NEXT clears the bank
// S_LOAD | one-cycle fetch of the oldest lap on entry to recall
// S_RCL  | recall: NEXT steps to the next stored lap, wrapping to the oldest
module lap_bank_ctrl #(
   parameter int AW = 2
) (
   input  logic          CP,
   input  logic          RST,
   input  logic          MODE,
   input  logic          LAP,
   input  logic          NEXT,
   input  logic [7:0]    min,
   input  logic [7:0]    s,
   input  logic [7:0]    ms,
   output logic [23:0]   Dout,
   output logic [AW-1:0] IDX,
   output logic [AW:0]   CNT,
   output logic          FULL,
   output logic          EMPTY,
   output logic          ZERO
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   localparam logic [1:0] S_REC  = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RCL  = 2'd2;

   logic [1:0]    state;
   logic [23:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic          LAP_d;
   logic          NEXT_d;
   logic          armed;

   logic          lap_p;
   logic          nxt_p;
   logic [23:0]   live;
   logic [AW-1:0] oldest;
   logic [AW:0]   cnt_m1;
   logic [AW-1:0] idx_nxt;
   logic [AW-1:0] step_addr;
   logic          store;

   // Key edge pulses, flags and address arithmetic. The armed flag masks the
   // first cycle after reset so a key already held during reset gives no pulse.
   always_comb begin
      lap_p     = armed & LAP & ~LAP_d;
      nxt_p     = armed & NEXT & ~NEXT_d;
      live      = {min, s, ms};
      FULL      = (CNT == DEPTH_C);
      EMPTY     = (CNT == '0);
      oldest    = wp - CNT[AW-1:0];
      cnt_m1    = CNT - (AW+1)'(1);
      idx_nxt   = ({1'b0, IDX} == cnt_m1) ? '0 : IDX + AW'(1);
      step_addr = oldest + idx_nxt;
`ifdef LAP_OVERWRITE_EN
      store     = RST && (state == S_REC) && lap_p && !nxt_p;
`else
      store     = RST && (state == S_REC) && lap_p && !nxt_p && !FULL;
`endif
   end

   // Lap storage; contents are don't-care after a clear so no reset is needed.
   always_ff @(posedge CP) begin
      if (store)
         mem[wp] <= live;
   end

   // Sequencing FSM, bank pointers and registered display outputs.
   always_ff @(posedge CP) begin
      if (!RST) begin
         state  <= S_REC;
         Dout   <= '0;
         ZERO   <= 1'b1;
         IDX    <= '0;
         CNT    <= '0;
         wp     <= '0;
         LAP_d  <= 1'b0;
         NEXT_d <= 1'b0;
         armed  <= 1'b0;
      end else begin
         LAP_d  <= LAP;
         NEXT_d <= NEXT;
         armed  <= 1'b1;
         case (state)
            S_REC: begin
               if (nxt_p) begin
                  CNT  <= '0;
                  wp   <= '0;
                  Dout <= '0;
                  ZERO <= 1'b1;
               end else if (store) begin
                  wp   <= wp + AW'(1);
                  if (!FULL)
                     CNT <= CNT + (AW+1)'(1);
                  Dout <= live;
                  ZERO <= (live == 24'd0);
               end
               if (MODE)
                  state <= S_LOAD;
            end
            S_LOAD: begin
               if (!MODE) begin
                  state <= S_REC;
               end else begin
                  IDX   <= '0;
                  state <= S_RCL;
                  if (EMPTY) begin
                     Dout <= '0;
                     ZERO <= 1'b1;
                  end else begin
                     Dout <= mem[oldest];
                     ZERO <= (mem[oldest] == 24'd0);
                  end
               end
            end
            S_RCL: begin
               if (!MODE) begin
                  state <= S_REC;
               end else if (nxt_p && !EMPTY) begin
                  IDX  <= idx_nxt;
                  Dout <= mem[step_addr];
                  ZERO <= (mem[step_addr] == 24'd0);
               end
            end
            default: state <= S_REC;
         endcase
      end
   end

endmodule

// File: tb/tb_lap_bank_ctrl.sv
// Testbench for lap_bank_ctrl: directed stimulus pushes expected output sets
// into a queue; a monitor on the falling edge pops and compares them.
module tb_lap_bank_ctrl;

   logic        CP = 1'b0;
   logic        RST, MODE, LAP, NEXT;
   logic [7:0]  min, s, ms;
   logic [23:0] Dout;
   logic [1:0]  IDX;
   logic [2:0]  CNT;
   logic        FULL, EMPTY, ZERO;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [23:0] dout;
      logic [1:0]  idx;
      logic [2:0]  cnt;
   } exp_t;

   exp_t q[$];
   exp_t e;

   lap_bank_ctrl #(.AW(2)) dut (
      .CP(CP), .RST(RST), .MODE(MODE), .LAP(LAP), .NEXT(NEXT),
      .min(min), .s(s), .ms(ms),
      .Dout(Dout), .IDX(IDX), .CNT(CNT),
      .FULL(FULL), .EMPTY(EMPTY), .ZERO(ZERO)
   );

   always #5 CP = ~CP;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, time=%0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string nm, input string fld, input logic [23:0] act,
                      input logic [23:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got 0x%0h, required 0x%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: every expectation pushed after an edge is checked half a cycle later.
   always @(negedge CP) begin
      while (q.size() > 0) begin
         e = q.pop_front();
         cmp(e.name, "Dout",  Dout,  e.dout);
         cmp(e.name, "IDX",   24'(IDX), 24'(e.idx));
         cmp(e.name, "CNT",   24'(CNT), 24'(e.cnt));
         cmp(e.name, "ZERO",  24'(ZERO),  24'(e.dout == 24'd0));
         cmp(e.name, "FULL",  24'(FULL),  24'(e.cnt == 3'd4));
         cmp(e.name, "EMPTY", 24'(EMPTY), 24'(e.cnt == 3'd0));
      end
   end

   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   task automatic expect_out(input string nm, input logic [23:0] d,
                             input logic [1:0] i, input logic [2:0] c);
      exp_t x;
      x.name = nm; x.dout = d; x.idx = i; x.cnt = c;
      q.push_back(x);
   endtask

   task automatic set_time(input logic [23:0] t);
      {min, s, ms} = t;
   endtask

   // One lap key press: rising edge evaluated at the first tick, then release.
   task automatic lap_press(input logic [23:0] t, input string nm,
                            input logic [23:0] d, input logic [2:0] c);
      set_time(t);
      LAP = 1'b1;
      tick();
      expect_out(nm, d, 2'd0, c);
      LAP = 1'b0;
      tick();
   endtask

   task automatic next_press(input string nm, input logic [23:0] d,
                             input logic [1:0] i, input logic [2:0] c);
      NEXT = 1'b1;
      tick();
      expect_out(nm, d, i, c);
      NEXT = 1'b0;
      tick();
   endtask

   task automatic enter_recall(input string nm, input logic [23:0] prev_d,
                               input logic [1:0] prev_i, input logic [23:0] d,
                               input logic [2:0] c);
      MODE = 1'b1;
      tick();
      expect_out({nm, "_pend"}, prev_d, prev_i, c);
      tick();
      expect_out(nm, d, 2'd0, c);
   endtask

   logic [23:0] laps [5];

   initial begin
      RST = 1'b0; MODE = 1'b0; LAP = 1'b0; NEXT = 1'b0;
      set_time(24'h0);
      laps[0] = 24'h001122; laps[1] = 24'h002233; laps[2] = 24'h003344;
      laps[3] = 24'h004455; laps[4] = 24'h005566;
      tick(); tick();
      expect_out("reset", 24'h0, 2'd0, 3'd0);
      RST = 1'b1;
      tick();
      expect_out("release", 24'h0, 2'd0, 3'd0);

      // Record three laps, then hold LAP high with a changed time.
      lap_press(24'h010203, "lap1", 24'h010203, 3'd1);
      lap_press(24'h020304, "lap2", 24'h020304, 3'd2);
      lap_press(24'h030405, "lap3", 24'h030405, 3'd3);
      set_time(24'h040506);
      LAP = 1'b1;
      tick();
      expect_out("lap4_first", 24'h040506, 2'd0, 3'd4);
      set_time(24'h090909);
      repeat (10) tick();
      expect_out("lap_hold", 24'h040506, 2'd0, 3'd4);
      LAP = 1'b0;
      tick();

      // Clear, re-record three laps, then recall with wraparound.
      next_press("clear0", 24'h0, 2'd0, 3'd0);
      lap_press(24'h010203, "rlap1", 24'h010203, 3'd1);
      lap_press(24'h020304, "rlap2", 24'h020304, 3'd2);
      lap_press(24'h030405, "rlap3", 24'h030405, 3'd3);
      enter_recall("rcl0", 24'h030405, 2'd0, 24'h010203, 3'd3);
      next_press("step1", 24'h020304, 2'd1, 3'd3);
      next_press("step2", 24'h030405, 2'd2, 3'd3);
      next_press("step_wrap", 24'h010203, 2'd0, 3'd3);
      set_time(24'h777777);
      LAP = 1'b1; tick(); LAP = 1'b0; tick();
      expect_out("lap_in_rcl", 24'h010203, 2'd0, 3'd3);

      // Reset while recalling at IDX 2; LAP held through reset must not store.
      next_press("step1b", 24'h020304, 2'd1, 3'd3);
      next_press("step2b", 24'h030405, 2'd2, 3'd3);
      RST = 1'b0; MODE = 1'b0; LAP = 1'b1;
      tick();
      expect_out("rst_rcl", 24'h0, 2'd0, 3'd0);
      RST = 1'b1;
      tick();
      tick();
      expect_out("held_lap", 24'h0, 2'd0, 3'd0);
      LAP = 1'b0;
      tick();

      // Simultaneous LAP and NEXT with two laps stored: clear wins.
      lap_press(24'h111111, "c_lap1", 24'h111111, 3'd1);
      lap_press(24'h222222, "c_lap2", 24'h222222, 3'd2);
      set_time(24'h333333);
      LAP = 1'b1; NEXT = 1'b1;
      tick();
      expect_out("both_clear", 24'h0, 2'd0, 3'd0);
      LAP = 1'b0; NEXT = 1'b0;
      tick();
      enter_recall("rcl_empty", 24'h0, 2'd0, 24'h0, 3'd0);
      next_press("step_empty", 24'h0, 2'd0, 3'd0);
      MODE = 1'b0;
      tick(); tick();

      // Five laps into a four-entry bank.
      for (int i = 0; i < 4; i++)
         lap_press(laps[i], $sformatf("fill%0d", i), laps[i], 3'(i + 1));
`ifdef LAP_OVERWRITE_EN
      lap_press(laps[4], "fill4", laps[4], 3'd4);
      enter_recall("rcl_full", laps[4], 2'd0, laps[1], 3'd4);
      next_press("full_s1", laps[2], 2'd1, 3'd4);
      next_press("full_s2", laps[3], 2'd2, 3'd4);
      next_press("full_s3", laps[4], 2'd3, 3'd4);
      next_press("full_s4", laps[1], 2'd0, 3'd4);
`else
      lap_press(laps[4], "fill4", laps[3], 3'd4);
      enter_recall("rcl_full", laps[3], 2'd0, laps[0], 3'd4);
      next_press("full_s1", laps[1], 2'd1, 3'd4);
      next_press("full_s2", laps[2], 2'd2, 3'd4);
      next_press("full_s3", laps[3], 2'd3, 3'd4);
      next_press("full_s4", laps[0], 2'd0, 3'd4);
`endif
      // Back to record: Dout holds the recalled value, IDX holds.
      next_press("full_s5", laps[
`ifdef LAP_OVERWRITE_EN
         2
`else
         1
`endif
         ], 2'd1, 3'd4);
      MODE = 1'b0;
      tick(); tick();
      expect_out("back_rec", laps[
`ifdef LAP_OVERWRITE_EN
         2
`else
         1
`endif
         ], 2'd1, 3'd4);

      tick(); tick();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
